// File: rtl/riscv_bus_pkg.sv
// Shared types and constants for the core-to-peripheral bus bridge.
package riscv_bus_pkg;

    localparam logic [11:0] APB_BASE       = 12'h100;
    localparam logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF;
    localparam logic [31:0] UNMAPPED_RDATA = 32'h0;

    typedef enum logic [2:0] {
        IDLE,
        RAM_WAIT,
        SETUP,
        ACCESS,
        DONE
    } bus_state_e;

    // Core request as captured in IDLE and held for the rest of the transfer.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: classifies a core address as RAM, APB slot or unmapped.
//   mem_addr    : core byte address
//   is_ram      : address lies in the RAM region (takes priority over APB)
//   is_apb      : address lies in one of the NUM_SLAVES APB slots
//   apb_idx     : slot index, meaningful only when is_apb = 1
//   is_unmapped : neither of the above
module bus_addr_decode
    import riscv_bus_pkg::*;
#(
    parameter  int unsigned NUM_SLAVES = 2,
    parameter  logic [3:0]  RAM_REGION = 4'h0,
    localparam int unsigned IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [31:0]      mem_addr,
    output logic             is_ram,
    output logic             is_apb,
    output logic [IDX_W-1:0] apb_idx,
    output logic             is_unmapped
);

    logic [11:0] apb_off;
    logic        unused_low;

    // Offset from the APB base wraps below it, so one unsigned compare bounds both sides.
    assign apb_off     = mem_addr[31:20] - APB_BASE;
    assign is_ram      = (mem_addr[31:28] == RAM_REGION);
    assign is_apb      = !is_ram && (apb_off < 12'(NUM_SLAVES));
    assign is_unmapped = !is_ram && !is_apb;
    assign apb_idx     = IDX_W'(apb_off);
    assign unused_low  = ^mem_addr[19:0];

endmodule

// File: rtl/mem_apb_bridge.sv
// PicoRV32 native memory port to RAM / APB bridge with per-transfer timeout.
//   clk, resetn                          : clock, asynchronous active-low reset
//   mem_valid/addr/wdata/wstrb           : core request (wstrb = 0 is a read)
//   mem_ready/mem_rdata/bus_err          : one-cycle registered completion
//   ram_valid/addr/wdata/wstrb, ram_ready/rdata : RAM port
//   psel/penable/pwrite/paddr/pwdata/pstrb      : APB master outputs
//   prdata/pready/pslverr                : per-slave APB responses (flattened)
module mem_apb_bridge
    import riscv_bus_pkg::*;
#(
    parameter int unsigned NUM_SLAVES     = 2,
    parameter int unsigned PADDR_W        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [3:0]  RAM_REGION     = 4'h0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       mem_valid,
    input  logic [31:0]                mem_addr,
    input  logic [31:0]                mem_wdata,
    input  logic [3:0]                 mem_wstrb,
    output logic                       mem_ready,
    output logic [31:0]                mem_rdata,
    output logic                       ram_valid,
    output logic [15:0]                ram_addr,
    output logic [31:0]                ram_wdata,
    output logic [3:0]                 ram_wstrb,
    input  logic                       ram_ready,
    input  logic [31:0]                ram_rdata,
    output logic [NUM_SLAVES-1:0]      psel,
    output logic                       penable,
    output logic                       pwrite,
    output logic [PADDR_W-1:0]         paddr,
    output logic [31:0]                pwdata,
    output logic [3:0]                 pstrb,
    input  logic [NUM_SLAVES*32-1:0]   prdata,
    input  logic [NUM_SLAVES-1:0]      pready,
    input  logic [NUM_SLAVES-1:0]      pslverr,
    output logic                       bus_err
);

    localparam int unsigned IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    bus_state_e        state_q, state_d;
    mem_req_t          req_q, req_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic                  dec_ram, dec_apb, dec_unm;
    logic [IDX_W-1:0]      dec_idx;
    logic                  sel_pready, sel_pslverr;
    logic [31:0]           sel_prdata;
    logic                  apb_d;

    logic                  mem_ready_d, ram_valid_d, penable_d, pwrite_d, bus_err_d;
    logic [31:0]           mem_rdata_d, ram_wdata_d, pwdata_d;
    logic [15:0]           ram_addr_d;
    logic [3:0]            ram_wstrb_d, pstrb_d;
    logic [NUM_SLAVES-1:0] psel_d;
    logic [PADDR_W-1:0]    paddr_d;

    bus_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .RAM_REGION (RAM_REGION)
    ) u_decode (
        .mem_addr    (mem_addr),
        .is_ram      (dec_ram),
        .is_apb      (dec_apb),
        .apb_idx     (dec_idx),
        .is_unmapped (dec_unm)
    );

    // Response of the slave owning the current transfer; all others are ignored.
    assign sel_pready  = pready[idx_q];
    assign sel_pslverr = pslverr[idx_q];
    assign sel_prdata  = prdata[{idx_q, 5'd0} +: 32];

    // Next state, captured request/response, and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    req_d   = '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};
                    idx_d   = dec_idx;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (dec_ram) begin
                        state_d = RAM_WAIT;
                    end else if (dec_apb) begin
                        state_d = SETUP;
                    end else if (dec_unm) begin
                        rdata_d = UNMAPPED_RDATA;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RAM_WAIT: begin
                if (ram_ready) begin
                    rdata_d = ram_rdata;
                    state_d = DONE;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (sel_pready) begin
                    rdata_d = sel_prdata;
                    err_d   = sel_pslverr;
                    state_d = DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
                    rdata_d = ERR_RDATA;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        apb_d       = (state_d == SETUP) || (state_d == ACCESS);
        mem_ready_d = (state_d == DONE);
        mem_rdata_d = mem_ready_d ? rdata_d : '0;
        bus_err_d   = mem_ready_d && err_d;
        ram_valid_d = (state_d == RAM_WAIT);
        ram_addr_d  = ram_valid_d ? req_d.addr[15:0] : '0;
        ram_wdata_d = ram_valid_d ? req_d.wdata : '0;
        ram_wstrb_d = ram_valid_d ? req_d.wstrb : '0;
        psel_d      = apb_d ? (NUM_SLAVES'(1) << idx_d) : '0;
        penable_d   = (state_d == ACCESS);
        pwrite_d    = apb_d && (|req_d.wstrb);
        paddr_d     = apb_d ? req_d.addr[PADDR_W-1:0] : '0;
        pwdata_d    = apb_d ? req_d.wdata : '0;
        pstrb_d     = apb_d ? req_d.wstrb : '0;
    end

    // State, capture and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            req_q     <= '0;
            idx_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            bus_err   <= 1'b0;
            ram_valid <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wstrb <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            idx_q     <= idx_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            mem_ready <= mem_ready_d;
            mem_rdata <= mem_rdata_d;
            bus_err   <= bus_err_d;
            ram_valid <= ram_valid_d;
            ram_addr  <= ram_addr_d;
            ram_wdata <= ram_wdata_d;
            ram_wstrb <= ram_wstrb_d;
            psel      <= psel_d;
            penable   <= penable_d;
            pwrite    <= pwrite_d;
            paddr     <= paddr_d;
            pwdata    <= pwdata_d;
            pstrb     <= pstrb_d;
        end
    end

endmodule

// File: tb/tb_mem_apb_bridge.sv
// Self-checking bench for mem_apb_bridge: transaction-level timing model plus directed literal checks.
module tb_mem_apb_bridge;

    localparam int NS = 2;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              mem_valid;
    logic [31:0]       mem_addr, mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic              ram_valid;
    logic [15:0]       ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_wstrb;
    logic              ram_ready;
    logic [31:0]       ram_rdata;
    logic [NS-1:0]     psel;
    logic              penable, pwrite;
    logic [7:0]        paddr;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [NS*32-1:0]  prdata;
    logic [NS-1:0]     pready, pslverr;
    logic              bus_err;

    mem_apb_bridge #(
        .NUM_SLAVES     (NS),
        .PADDR_W        (8),
        .TIMEOUT_CYCLES (TO),
        .RAM_REGION     (4'h0)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .ram_valid (ram_valid),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wstrb (ram_wstrb),
        .ram_ready (ram_ready),
        .ram_rdata (ram_rdata),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: kind 0 = RAM, 1 = APB, 2 = unmapped; timing relative to the request cycle.
    logic        chk_en = 1'b0;
    logic        exp_act = 1'b0;
    int          exp_start, exp_kind, exp_idx, exp_w, exp_acc, exp_done;
    logic [31:0] exp_addr, exp_wdata, exp_rdata, exp_rd_in;
    logic [3:0]  exp_wstrb;
    logic        exp_err, exp_serr_in;

    always @(negedge clk) begin : cmp
        int          rel;
        logic        e_ready, e_ram, e_pen;
        logic [1:0]  e_psel;
        if (chk_en && resetn) begin
            rel     = cyc - exp_start;
            e_ready = 1'b0;
            e_ram   = 1'b0;
            e_pen   = 1'b0;
            e_psel  = 2'b00;
            if (exp_act) begin
                e_ready = (rel == exp_done);
                if (exp_kind == 0)
                    e_ram = (rel >= 1) && (rel <= 1 + exp_w);
                if (exp_kind == 1 && rel >= 1 && rel <= 1 + exp_acc) begin
                    e_psel = 2'(2'b01 << exp_idx);
                    e_pen  = (rel >= 2);
                end
            end
            check("mem_ready", 32'(mem_ready), 32'(e_ready));
            check("mem_rdata", mem_rdata, e_ready ? exp_rdata : 32'h0);
            check("bus_err", 32'(bus_err), 32'(e_ready && exp_err));
            check("ram_valid", 32'(ram_valid), 32'(e_ram));
            check("psel", 32'(psel), 32'(e_psel));
            check("penable", 32'(penable), 32'(e_pen));
            if (e_ram) begin
                check("ram_addr", 32'(ram_addr), 32'(exp_addr[15:0]));
                check("ram_wdata", ram_wdata, exp_wdata);
                check("ram_wstrb", 32'(ram_wstrb), 32'(exp_wstrb));
            end
            if (e_psel != 2'b00) begin
                check("paddr", 32'(paddr), 32'(exp_addr[7:0]));
                check("pwrite", 32'(pwrite), 32'(exp_wstrb != 4'h0));
                check("pwdata", pwdata, exp_wdata);
                check("pstrb", 32'(pstrb), 32'(exp_wstrb));
            end
        end
    end

    // Random slave/RAM traffic; the owner of the current transfer answers on its scheduled cycle.
    task automatic drive_slaves(input int rel);
        ram_ready = 1'($urandom_range(0, 1));
        ram_rdata = $urandom;
        pready    = 2'($urandom);
        pslverr   = 2'($urandom);
        prdata    = {$urandom, $urandom};
        if (exp_act && exp_kind == 0) begin
            ram_ready = (rel == 1 + exp_w);
            if (ram_ready) ram_rdata = exp_rd_in;
        end
        if (exp_act && exp_kind == 1) begin
            pready[exp_idx] = (exp_w < TO) && (rel == 2 + exp_w);
            if (pready[exp_idx]) begin
                prdata[exp_idx*32 +: 32] = exp_rd_in;
                pslverr[exp_idx]         = exp_serr_in;
            end
        end
    endtask

    task automatic idle(input int n);
        mem_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive_slaves(cyc - exp_start);
            @(posedge clk);
            #1;
        end
    endtask

    // Issues one request (called #1 after a rising edge) and runs exactly as long as the model says.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                           input int w, input logic serr, input logic [31:0] rd,
                           output int lat, output logic [31:0] got_rdata, output logic got_err,
                           output int pen_cnt, output logic [1:0] psel_seen);
        if (a[31:28] == 4'h0) begin
            exp_kind = 0; exp_idx = 0;
            exp_done = 2 + w; exp_rdata = rd; exp_err = 1'b0;
        end else if (a[31:20] == 12'h100 || a[31:20] == 12'h101) begin
            exp_kind = 1; exp_idx = int'(a[31:20] - 12'h100);
            exp_acc  = (w < TO) ? w + 1 : TO;
            exp_done = 2 + exp_acc;
            exp_rdata = (w < TO) ? rd : 32'hFFFF_FFFF;
            exp_err   = (w < TO) ? serr : 1'b1;
        end else begin
            exp_kind = 2; exp_idx = 0;
            exp_done = 1; exp_rdata = 32'h0; exp_err = 1'b1;
        end
        exp_w = w; exp_addr = a; exp_wdata = wd; exp_wstrb = ws;
        exp_rd_in = rd; exp_serr_in = serr;
        exp_start = cyc; exp_act = 1'b1;
        mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
        lat = -1; got_rdata = 32'h0; got_err = 1'b0; pen_cnt = 0; psel_seen = 2'b00;
        for (int rel = 0; rel <= exp_done; rel++) begin
            drive_slaves(rel);
            @(negedge clk);
            if (mem_ready && lat < 0) begin
                lat = rel; got_rdata = mem_rdata; got_err = bus_err;
            end
            if (penable) pen_cnt++;
            psel_seen = psel_seen | psel;
            @(posedge clk);
            #1;
        end
        mem_valid = 1'b0;
    endtask

    int          lat, pen;
    logic [31:0] grd;
    logic        gerr;
    logic [1:0]  gps;
    logic        found;

    initial begin
        resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        ram_ready = 1'b0; ram_rdata = '0; pready = '0; pslverr = '0; prdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_ready", 32'(mem_ready), 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        check("rst_ram_valid", 32'(ram_valid), 32'h0);
        check("rst_psel", 32'(psel), 32'h0);
        check("rst_penable", 32'(penable), 32'h0);
        check("rst_paddr", 32'(paddr), 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // RAM read with one wait cycle.
        run_txn(32'h0000_0040, 32'h0, 4'h0, 1, 1'b0, 32'h1234_5678, lat, grd, gerr, pen, gps);
        check("ram_lat", 32'(lat), 32'd3);
        check("ram_rdata", grd, 32'h1234_5678);
        check("ram_err", 32'(gerr), 32'h0);
        idle(1);
        // UART write, two wait states.
        run_txn(32'h1000_0004, 32'h0000_00A5, 4'hF, 2, 1'b0, 32'h0, lat, grd, gerr, pen, gps);
        check("uart_lat", 32'(lat), 32'd5);
        check("uart_psel", 32'(gps), 32'h1);
        check("uart_access_len", 32'(pen), 32'd3);
        // Timer read, zero wait states, then an unmapped read back-to-back.
        run_txn(32'h1010_0008, 32'h0, 4'h0, 0, 1'b0, 32'h0000_00FF, lat, grd, gerr, pen, gps);
        check("timer_lat", 32'(lat), 32'd3);
        check("timer_rdata", grd, 32'h0000_00FF);
        check("timer_psel", 32'(gps), 32'h2);
        run_txn(32'h2000_0000, 32'h0, 4'h0, 0, 1'b0, 32'h0, lat, grd, gerr, pen, gps);
        check("unm_lat", 32'(lat), 32'd1);
        check("unm_rdata", grd, 32'h0);
        check("unm_err", 32'(gerr), 32'h1);
        check("unm_psel", 32'(gps), 32'h0);
        // Slave that never answers.
        run_txn(32'h1000_0000, 32'h0, 4'h0, 100, 1'b0, 32'h0, lat, grd, gerr, pen, gps);
        check("to_access_len", 32'(pen), 32'd4);
        check("to_rdata", grd, 32'hFFFF_FFFF);
        check("to_err", 32'(gerr), 32'h1);
        check("to_lat", 32'(lat), 32'd6);
        run_txn(32'h1010_000C, 32'h0, 4'h0, 0, 1'b0, 32'h0000_1111, lat, grd, gerr, pen, gps);
        check("after_to_rdata", grd, 32'h0000_1111);
        check("after_to_err", 32'(gerr), 32'h0);
        // Slave error with data passed through.
        run_txn(32'h1000_0020, 32'h0, 4'h0, 1, 1'b1, 32'hDEAD_BEEF, lat, grd, gerr, pen, gps);
        check("slverr_lat", 32'(lat), 32'd4);
        check("slverr_rdata", grd, 32'hDEAD_BEEF);
        check("slverr_err", 32'(gerr), 32'h1);

        // Reset asserted while penable is high.
        idle(1);
        chk_en = 1'b0; exp_act = 1'b0;
        pready = '0; pslverr = '0; ram_ready = 1'b0;
        mem_valid = 1'b1; mem_addr = 32'h1000_0010; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (penable) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("rst_mid_found_access", 32'(found), 32'h1);
        #2 resetn = 1'b0;
        #1;
        check("rst_mid_psel", 32'(psel), 32'h0);
        check("rst_mid_penable", 32'(penable), 32'h0);
        check("rst_mid_mem_ready", 32'(mem_ready), 32'h0);
        mem_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        run_txn(32'h1000_0010, 32'h0, 4'h0, 1, 1'b0, 32'h5A5A_0001, lat, grd, gerr, pen, gps);
        check("post_rst_lat", 32'(lat), 32'd4);
        check("post_rst_rdata", grd, 32'h5A5A_0001);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            int          k;
            logic [31:0] a;
            logic [3:0]  ws;
            k = $urandom_range(0, 3);
            case (k)
                0:       a = {4'h0, 28'($urandom)};
                1:       a = {12'h100, 20'($urandom)};
                2:       a = {12'h101, 20'($urandom)};
                default: a = ($urandom_range(0, 1) == 1) ? {4'($urandom_range(2, 15)), 28'($urandom)}
                                                         : {4'h1, 8'($urandom_range(2, 255)), 20'($urandom)};
            endcase
            ws = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            run_txn(a, $urandom, ws, $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom,
                    lat, grd, gerr, pen, gps);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_apb_bridge.md
Name: mem_apb_bridge

Overview:
- Controller between the PicoRV32 native memory port and the subsystem's memory/peripheral resources.
- Decodes each core request into one of three targets: the RAM port, one of NUM_SLAVES APB slaves, or an unmapped region.
- Runs proper APB SETUP/ACCESS sequencing and muxes the response back as a single-cycle mem_ready pulse.
- Adds a per-transfer timeout so a hung slave cannot stall the core.

Parameters:
- NUM_SLAVES, 2: APB slave count. Slave i is decoded at mem_addr[31:20] == 12'h100 + i.
- PADDR_W, 8: APB address width. paddr = mem_addr[PADDR_W-1:0].
- TIMEOUT_CYCLES, 64: maximum ACCESS cycles before forced completion. 0 disables the timeout.
- RAM_REGION, 4'h0: RAM is selected when mem_addr[31:28] == RAM_REGION.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  core request valid
- mem_addr  in  32  core byte address
- mem_wdata  in  32  core write data
- mem_wstrb  in  4  byte strobes; 0 = read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, valid while mem_ready = 1
- ram_valid  out  1  RAM request
- ram_addr  out  16  RAM address
- ram_wdata  out  32  RAM write data
- ram_wstrb  out  4  RAM byte strobes
- ram_ready  in  1  RAM completion
- ram_rdata  in  32  RAM read data
- psel  out  NUM_SLAVES  one-hot APB select
- penable  out  1  APB enable
- pwrite  out  1  APB write
- paddr  out  PADDR_W  APB address
- pwdata  out  32  APB write data
- pstrb  out  4  APB byte strobes
- prdata  in  NUM_SLAVES*32  flattened slave read data; slave i occupies bits [32i+31:32i]
- pready  in  NUM_SLAVES  per-slave ready
- pslverr  in  NUM_SLAVES  per-slave error
- bus_err  out  1  one-cycle error pulse, coincident with mem_ready

Behaviour:
- Reset (asynchronous): state = IDLE; every output 0; captured request registers 0; timeout counter 0.
- All outputs are registered.
- States: IDLE, RAM_WAIT, SETUP, ACCESS, DONE.
- IDLE:
  - On mem_valid = 1, capture addr, wdata and wstrb, and record the selected slave index.
  - Next state: RAM_WAIT if the RAM region matches; SETUP if an APB slot matches; otherwise DONE with error.
  - An address matching no region is unmapped. Unmapped reads return rdata = 32'h0; unmapped writes are dropped; bus_err = 1.
- RAM_WAIT:
  - ram_valid = 1, with captured addr[15:0], wdata and wstrb.
  - On ram_ready: capture ram_rdata and go to DONE.
- SETUP (exactly 1 cycle):
  - psel[idx] = 1, penable = 0.
  - pwrite = |wstrb; pstrb = wstrb (0 on reads).
  - Next state: ACCESS.
- ACCESS:
  - psel[idx] = 1, penable = 1. Address, control and data are held stable.
  - pready[idx] = 1: capture prdata[idx]. If pslverr[idx] = 1, bus_err is pulsed in DONE. Go to DONE.
  - Timeout: if the counter reaches TIMEOUT_CYCLES with no pready, complete with rdata = 32'hFFFF_FFFF and bus_err = 1. Go to DONE.
  - The counter clears on entry to ACCESS.
- psel and penable deassert on the cycle after the completing ACCESS cycle. psel is never active in IDLE or DONE.
- pready and pslverr of unselected slaves are ignored.
- DONE:
  - mem_ready = 1 for exactly 1 cycle; mem_rdata = captured data; bus_err as determined above.
  - Next state: IDLE. mem_rdata returns to 0 afterwards.
- Latency from the first mem_valid cycle to the mem_ready cycle:
  - APB, zero wait states: 3 cycles.
  - APB, each wait state: +1 cycle.
  - RAM: 2 + RAM wait cycles.
  - Unmapped: 1 cycle.
- Back-to-back requests: mem_valid seen in IDLE on the cycle after DONE starts a new transfer, with no bubble beyond IDLE.
- mem_valid deasserting mid-transfer is ignored; the transfer completes (the core never does this).
- Reset asserted mid-ACCESS: psel and penable drop immediately (asynchronously); no mem_ready is issued.

Decomposition:
- Package riscv_bus_pkg holds:
  - the state enum;
  - APB_BASE = 12'h100;
  - ERR_RDATA = 32'hFFFF_FFFF;
  - UNMAPPED_RDATA = 32'h0.
- One sub-module, bus_addr_decode (combinational). It takes mem_addr and outputs is_ram, is_apb, apb_idx and is_unmapped. It is parameterised by NUM_SLAVES and RAM_REGION.

Test Plan:
- RAM read: addr 0x0000_0040, ram_ready after 1 cycle with ram_rdata 0x1234_5678 -> mem_ready 3 cycles after mem_valid, mem_rdata 0x1234_5678, bus_err 0.
- UART write: addr 0x1000_0004, wdata 0xA5, wstrb 4'hF, pready[0] after 2 wait cycles -> psel = 2'b01, paddr 0x04, pwrite 1, pstrb 4'hF; ACCESS held 3 cycles; mem_ready 5 cycles after mem_valid.
- Timer read: addr 0x1010_0008, zero wait states, prdata[1] = 0x0000_00FF -> psel = 2'b10, pwrite 0, pstrb 0; mem_rdata 0xFF 3 cycles after mem_valid.
- Unmapped: addr 0x2000_0000 read -> no psel, no ram_valid; mem_ready and bus_err 1 cycle after mem_valid; mem_rdata 0.
- Timeout: TIMEOUT_CYCLES = 4, slave never asserts pready -> penable high exactly 4 cycles; mem_rdata 0xFFFF_FFFF; bus_err 1; next request serviced normally. Repeat with pslverr -> bus_err 1 and prdata passed through.
- Reset mid-ACCESS: resetn low while penable = 1 -> psel, penable and mem_ready are 0 the same cycle; after release, a fresh UART read completes normally.
